// File: rtl/lc3_dp_pkg.sv
// Shared types for the multi-cycle LC-3 datapath: control word layout, mux selects and memory FSM states.
package lc3_dp_pkg;

  typedef enum logic [2:0] {
    GATE_NONE   = 3'd0,
    GATE_PC     = 3'd1,
    GATE_MARMUX = 3'd2,
    GATE_ALU    = 3'd3,
    GATE_MDR    = 3'd4,
    GATE_PC_M1  = 3'd5
  } gate_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_AND   = 2'd1,
    ALU_NOT   = 2'd2,
    ALU_PASSA = 2'd3
  } aluk_e;

  typedef enum logic {
    ADDR1_PC  = 1'b0,
    ADDR1_SR1 = 1'b1
  } addr1_e;

  typedef enum logic [1:0] {
    ADDR2_ZERO  = 2'd0,
    ADDR2_OFF6  = 2'd1,
    ADDR2_OFF9  = 2'd2,
    ADDR2_OFF11 = 2'd3
  } addr2_e;

  typedef enum logic [1:0] {
    PCMUX_INC  = 2'd0,
    PCMUX_BUS  = 2'd1,
    PCMUX_ADDR = 2'd2
  } pcmux_e;

  typedef enum logic {
    MARMUX_ADDR  = 1'b0,
    MARMUX_ZEXT8 = 1'b1
  } marmux_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } mem_state_e;

  // Register indices are sized for the largest supported file; the datapath uses the low bits.
  localparam int REG_IDX_W = 5;

  typedef struct packed {
    gate_e                gate;
    aluk_e                aluk;
    addr1_e               addr1;
    addr2_e               addr2;
    pcmux_e               pcmux;
    marmux_e              marmux;
    logic                 ld_pc;
    logic                 ld_ir;
    logic                 ld_reg;
    logic                 ld_mar;
    logic                 ld_mdr;
    logic                 ld_cc;
    logic                 ld_ben;
    logic                 ld_psr;
    logic                 mem_en;
    logic                 mem_we;
    logic [REG_IDX_W-1:0] dr;
    logic [REG_IDX_W-1:0] sr1;
    logic [REG_IDX_W-1:0] sr2;
  } dm_ctrl_t;

  localparam int CTRL_W = $bits(dm_ctrl_t);

  function automatic logic calc_ben(input logic [2:0] irNzp, input logic n, input logic z,
                                    input logic p);
    return (irNzp[2] & n) | (irNzp[1] & z) | (irNzp[0] & p);
  endfunction

endpackage

// File: rtl/lc3_dp_regfile.sv
// General-purpose register file: NREG x DW, two asynchronous read ports, one synchronous write port.
module lc3_dp_regfile #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_addr_a,
  input  logic [AW-1:0] i_rd_addr_b,
  output logic [DW-1:0] o_rd_data_a,
  output logic [DW-1:0] o_rd_data_b
);

  logic [DW-1:0] r_regs [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data_a = r_regs[i_rd_addr_a];
  assign o_rd_data_b = r_regs[i_rd_addr_b];

endmodule

// File: rtl/lc3_datapath_mc.sv
// Multi-cycle LC-3 datapath around a single internal bus with a req/ack memory port.
// Define LC3_DATAPATH_ACV_EN to enable user-mode access-violation checking on MAR.
module lc3_datapath_mc
  import lc3_dp_pkg::*;
#(
  parameter int          DW       = 16,
  parameter int          NREG     = 8,
  parameter logic [15:0] RESET_PC = 16'h3000,
  parameter logic [15:0] USER_LO  = 16'h3000,
  parameter logic [15:0] IO_BASE  = 16'hFE00
) (
  input  logic          clk,
  input  logic          rst_n,
  input  dm_ctrl_t      i_ctrl,
  input  logic          i_ctrl_vld,
  output logic          o_ctrl_rdy,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [DW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_ack,
  output logic [3:0]    o_ir_op,
  output logic          o_ir_b11,
  output logic          o_ben,
  output logic          o_psr_15,
  output logic          o_acv
);

  localparam int AW = $clog2(NREG);

  mem_state_e    r_state;
  logic [DW-1:0] r_pc;
  logic [15:0]   r_ir;
  logic [DW-1:0] r_mar;
  logic [DW-1:0] r_mdr;
  logic          r_n;
  logic          r_z;
  logic          r_p;
  logic          r_ben;
  logic          r_psr15;
  logic          r_memWe;

  logic [DW-1:0] w_bus;
  logic [DW-1:0] w_sr1;
  logic [DW-1:0] w_sr2;
  logic [DW-1:0] w_aluB;
  logic [DW-1:0] w_aluOut;
  logic [DW-1:0] w_addr1;
  logic [DW-1:0] w_addr2;
  logic [DW-1:0] w_addrSum;
  logic [DW-1:0] w_marmux;
  logic [DW-1:0] w_pcNext;
  logic [DW-1:0] w_sext5;
  logic [DW-1:0] w_sext6;
  logic [DW-1:0] w_sext9;
  logic [DW-1:0] w_sext11;
  logic          w_accept;
  logic          w_acv;
  logic          w_busN;
  logic          w_busZ;
  logic          w_unusedIdx;

  assign w_accept = i_ctrl_vld && (r_state == ST_IDLE);

  assign w_sext5  = {{(DW-5){r_ir[4]}},   r_ir[4:0]};
  assign w_sext6  = {{(DW-6){r_ir[5]}},   r_ir[5:0]};
  assign w_sext9  = {{(DW-9){r_ir[8]}},   r_ir[8:0]};
  assign w_sext11 = {{(DW-11){r_ir[10]}}, r_ir[10:0]};

  lc3_dp_regfile #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (w_accept && i_ctrl.ld_reg),
    .i_wr_addr   (i_ctrl.dr[AW-1:0]),
    .i_wr_data   (w_bus),
    .i_rd_addr_a (i_ctrl.sr1[AW-1:0]),
    .i_rd_addr_b (i_ctrl.sr2[AW-1:0]),
    .o_rd_data_a (w_sr1),
    .o_rd_data_b (w_sr2)
  );

  // Index bits above log2(NREG) are don't-care for smaller register files.
  assign w_unusedIdx = ^{i_ctrl.dr, i_ctrl.sr1, i_ctrl.sr2};

  assign w_aluB = r_ir[5] ? w_sext5 : w_sr2;

  always_comb begin
    w_aluOut = w_sr1;
    case (i_ctrl.aluk)
      ALU_ADD:   w_aluOut = w_sr1 + w_aluB;
      ALU_AND:   w_aluOut = w_sr1 & w_aluB;
      ALU_NOT:   w_aluOut = ~w_sr1;
      ALU_PASSA: w_aluOut = w_sr1;
      default:   w_aluOut = w_sr1;
    endcase
  end

  assign w_addr1 = (i_ctrl.addr1 == ADDR1_SR1) ? w_sr1 : r_pc;

  always_comb begin
    w_addr2 = '0;
    case (i_ctrl.addr2)
      ADDR2_ZERO:  w_addr2 = '0;
      ADDR2_OFF6:  w_addr2 = w_sext6;
      ADDR2_OFF9:  w_addr2 = w_sext9;
      ADDR2_OFF11: w_addr2 = w_sext11;
      default:     w_addr2 = '0;
    endcase
  end

  assign w_addrSum = w_addr1 + w_addr2;
  assign w_marmux  = (i_ctrl.marmux == MARMUX_ZEXT8) ? DW'(r_ir[7:0]) : w_addrSum;

  always_comb begin
    w_bus = '0;
    case (i_ctrl.gate)
      GATE_NONE:   w_bus = '0;
      GATE_PC:     w_bus = r_pc;
      GATE_MARMUX: w_bus = w_marmux;
      GATE_ALU:    w_bus = w_aluOut;
      GATE_MDR:    w_bus = r_mdr;
      GATE_PC_M1:  w_bus = r_pc - DW'(1);
      default:     w_bus = '0;
    endcase
  end

  always_comb begin
    w_pcNext = r_pc + DW'(1);
    case (i_ctrl.pcmux)
      PCMUX_INC:  w_pcNext = r_pc + DW'(1);
      PCMUX_BUS:  w_pcNext = w_bus;
      PCMUX_ADDR: w_pcNext = w_addrSum;
      default:    w_pcNext = r_pc + DW'(1);
    endcase
  end

  assign w_busN = w_bus[DW-1];
  assign w_busZ = (w_bus == '0);

`ifdef LC3_DATAPATH_ACV_EN
  assign w_acv = r_psr15 && ((r_mar < DW'(USER_LO)) || (r_mar >= DW'(IO_BASE)));
`else
  logic w_unusedCfg;
  assign w_unusedCfg = ^{USER_LO, IO_BASE};
  assign w_acv       = 1'b0;
`endif

  // Architectural registers and the memory FSM share one edge so that every load in an
  // accepted word, including the transition into MEM, lands together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= DW'(RESET_PC);
      r_ir    <= '0;
      r_mar   <= '0;
      r_mdr   <= '0;
      r_n     <= 1'b0;
      r_z     <= 1'b1;
      r_p     <= 1'b0;
      r_ben   <= 1'b0;
      r_psr15 <= 1'b0;
      r_memWe <= 1'b0;
    end else begin
      if (w_accept) begin
        if (i_ctrl.ld_pc)  r_pc    <= w_pcNext;
        if (i_ctrl.ld_ir)  r_ir    <= w_bus[15:0];
        if (i_ctrl.ld_mar) r_mar   <= w_bus;
        if (i_ctrl.ld_psr) r_psr15 <= w_bus[15];
        if (i_ctrl.ld_mdr && !i_ctrl.mem_en) r_mdr <= w_bus;
        if (i_ctrl.ld_cc) begin
          r_n <= w_busN;
          r_z <= w_busZ;
          r_p <= !w_busN && !w_busZ;
        end
        if (i_ctrl.ld_ben) r_ben <= calc_ben(r_ir[11:9], r_n, r_z, r_p);
        if (i_ctrl.mem_en && !w_acv) begin
          r_state <= ST_MEM;
          r_memWe <= i_ctrl.mem_we;
        end
      end
      if ((r_state == ST_MEM) && i_mem_ack) begin
        r_state <= ST_IDLE;
        r_memWe <= 1'b0;
        if (!r_memWe) r_mdr <= i_mem_rdata;
      end
    end
  end

  assign o_ctrl_rdy  = (r_state == ST_IDLE);
  assign o_mem_req   = (r_state == ST_MEM);
  assign o_mem_we    = r_memWe;
  assign o_mem_addr  = r_mar;
  assign o_mem_wdata = r_mdr;
  assign o_ir_op     = r_ir[15:12];
  assign o_ir_b11    = r_ir[11];
  assign o_ben       = r_ben;
  assign o_psr_15    = r_psr15;
  assign o_acv       = w_acv;

endmodule
